burst_checker: RTL and testbench

BURST_CHECKER -- requirements
Module: burst_checker

---
 rtl/burst_checker.sv | 179 +++++++++++++++++
 tb/tb_burst_checker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_checker.sv
`default_nettype none
// ============================================================================
// Module      : burst_checker
// Description : Burst protocol checker. It accepts a start/len request, counts
//               the legal beats (valid with non-zero data) and flags zero-data
//               beats, over-long valid gaps and misplaced starts. It reports
//               completion (done) and violations (err, err_code, err_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module burst_checker #(
    parameter int DATA_W  = 4,
    parameter int LEN_W   = 4,
    parameter int MAX_GAP = 0,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic [LEN_W-1:0]  beat_cnt,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  err_cnt
);

    // The gap counter only has to reach MAX_GAP; one extra code keeps it >= 1 bit.
    localparam int                 c_GAP_W   = $clog2(MAX_GAP + 2);
    localparam logic [c_GAP_W-1:0] c_GAP_MAX = c_GAP_W'(MAX_GAP);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;

    localparam logic [1:0] c_ERR_NONE      = 2'd0;
    localparam logic [1:0] c_ERR_ZERO_DATA = 2'd1;
    localparam logic [1:0] c_ERR_GAP       = 2'd2;
    localparam logic [1:0] c_ERR_BAD_START = 2'd3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [LEN_W-1:0]   r_beat;
    logic [LEN_W-1:0]   w_beat_nxt;
    logic [LEN_W-1:0]   w_beat_inc;
    logic [c_GAP_W-1:0] r_gap;
    logic [c_GAP_W-1:0] w_gap_nxt;
    logic               r_busy;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic [1:0]         r_err_code;
    logic [1:0]         w_err_code_nxt;
    logic [CNT_W-1:0]   r_err_cnt;
    logic               w_last;

    assign w_beat_inc = r_beat + LEN_W'(1);
    // A legal beat that brings the count up to the latched length ends the burst.
    assign w_last     = valid && (data != '0) && (w_beat_inc == r_len);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and event decode; violations are tested in priority order
    // (zero data, then gap timeout, then bad start), so one edge yields one error.
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_beat_nxt     = r_beat;
        w_gap_nxt      = r_gap;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_err_code_nxt = r_err_code;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = c_ERR_BAD_START;
                    end else begin
                        w_state_nxt = BURST;
                        w_len_nxt   = len;
                        w_beat_nxt  = '0;
                        w_gap_nxt   = '0;
                    end
                end
            end
            BURST: begin
                if (valid && (data == '0)) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = c_ERR_ZERO_DATA;
                    w_state_nxt    = IDLE;
                end else if (!valid && (r_gap == c_GAP_MAX)) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = c_ERR_GAP;
                    w_state_nxt    = IDLE;
                end else if (start && !w_last) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = c_ERR_BAD_START;
                    w_state_nxt    = IDLE;
                end else begin
                    if (valid) begin
                        w_beat_nxt = w_beat_inc;
                        w_gap_nxt  = '0;
                    end else begin
                        w_gap_nxt  = r_gap + c_GAP_W'(1);
                    end
                    if (w_last) begin
                        if (start && (len != '0)) begin
                            // Back-to-back: close this burst and open the next one.
                            w_done_nxt = 1'b1;
                            w_len_nxt  = len;
                            w_beat_nxt = '0;
                            w_gap_nxt  = '0;
                        end else if (start) begin
                            // A zero-length follow-on request is still a bad start.
                            w_err_nxt      = 1'b1;
                            w_err_code_nxt = c_ERR_BAD_START;
                            w_state_nxt    = IDLE;
                        end else begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and registered status outputs; err_cnt saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= '0;
            r_beat     <= '0;
            r_gap      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= c_ERR_NONE;
            r_err_cnt  <= '0;
        end else begin
            r_len      <= w_len_nxt;
            r_beat     <= w_beat_nxt;
            r_gap      <= w_gap_nxt;
            r_busy     <= (w_state_nxt == BURST);
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
            if (w_err_nxt && (r_err_cnt != c_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign busy     = r_busy;
    assign beat_cnt = r_beat;
    assign done     = r_done;
    assign err      = r_err;
    assign err_code = r_err_code;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_burst_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_checker
// Description : Directed self-checking bench for burst_checker. Three
//               instances share stimulus: default parameters, MAX_GAP=2 and
//               CNT_W=2. Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] len = 4'd0;
    logic       valid = 1'b0;
    logic [3:0] data = 4'd0;

    logic       d_busy, d_done, d_err;
    logic [3:0] d_beat;
    logic [1:0] d_code;
    logic [7:0] d_cnt;

    logic       g_busy, g_done, g_err;
    logic [3:0] g_beat;
    logic [1:0] g_code;
    logic [7:0] g_cnt;

    logic       c_busy, c_done, c_err;
    logic [3:0] c_beat;
    logic [1:0] c_code;
    logic [1:0] c_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    burst_checker u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .valid(valid), .data(data),
        .busy(d_busy), .beat_cnt(d_beat), .done(d_done), .err(d_err),
        .err_code(d_code), .err_cnt(d_cnt)
    );

    burst_checker #(.MAX_GAP(2)) u_gap (
        .clk(clk), .rst(rst), .start(start), .len(len), .valid(valid), .data(data),
        .busy(g_busy), .beat_cnt(g_beat), .done(g_done), .err(g_err),
        .err_code(g_code), .err_cnt(g_cnt)
    );

    burst_checker #(.CNT_W(2)) u_cnt (
        .clk(clk), .rst(rst), .start(start), .len(len), .valid(valid), .data(data),
        .busy(c_busy), .beat_cnt(c_beat), .done(c_done), .err(c_err),
        .err_code(c_code), .err_cnt(c_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0; valid = 1'b0; data = 4'd0; len = 4'd0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic beat(input logic [3:0] d);
        valid = 1'b1; data = d;
        tick();
    endtask

    initial begin
        // Reset state
        do_reset();
        check_val("rst_busy", d_busy, 0);
        check_val("rst_beat", d_beat, 0);
        check_val("rst_done", d_done, 0);
        check_val("rst_err", d_err, 0);
        check_val("rst_code", d_code, 0);
        check_val("rst_cnt", d_cnt, 0);

        // Zero-data beat on the 4th beat
        start = 1'b1; len = 4'd4;
        tick();
        start = 1'b0;
        check_val("zd_busy_start", d_busy, 1);
        check_val("zd_beat_start", d_beat, 0);
        beat(4'd4); beat(4'd5); beat(4'd1);
        check_val("zd_beat3", d_beat, 3);
        beat(4'd0);
        check_val("zd_err", d_err, 1);
        check_val("zd_code", d_code, 1);
        check_val("zd_cnt", d_cnt, 1);
        check_val("zd_busy", d_busy, 0);
        check_val("zd_done", d_done, 0);
        valid = 1'b0;
        tick();
        check_val("zd_err_pulse", d_err, 0);
        check_val("zd_code_hold", d_code, 1);

        // Successful 4-beat burst; err_code survives done
        start = 1'b1; len = 4'd4;
        tick();
        start = 1'b0;
        beat(4'd4); beat(4'd5); beat(4'd1);
        check_val("ok_done_early", d_done, 0);
        beat(4'd2);
        check_val("ok_done", d_done, 1);
        check_val("ok_beat", d_beat, 4);
        check_val("ok_err", d_err, 0);
        check_val("ok_busy", d_busy, 0);
        valid = 1'b0;
        tick();
        check_val("ok_done_pulse", d_done, 0);
        check_val("ok_beat_hold", d_beat, 4);
        check_val("ok_code_kept", d_code, 1);
        check_val("ok_cnt_kept", d_cnt, 1);

        // Back-to-back bursts of length 2
        do_reset();
        start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0;
        beat(4'd3);
        start = 1'b1; len = 4'd2;
        beat(4'd5);
        start = 1'b0;
        check_val("b2b_done1", d_done, 1);
        check_val("b2b_busy1", d_busy, 1);
        check_val("b2b_beat1", d_beat, 0);
        check_val("b2b_err1", d_err, 0);
        beat(4'd6);
        check_val("b2b_done_pulse", d_done, 0);
        check_val("b2b_busy_mid", d_busy, 1);
        check_val("b2b_beat_mid", d_beat, 1);
        beat(4'd7);
        check_val("b2b_done2", d_done, 1);
        check_val("b2b_busy_end", d_busy, 0);
        check_val("b2b_beat2", d_beat, 2);
        check_val("b2b_cnt", d_cnt, 0);
        valid = 1'b0;
        tick();

        // Start on the first beat edge is a bad start
        start = 1'b1; len = 4'd2;
        tick();
        valid = 1'b1; data = 4'd3;
        tick();
        start = 1'b0; valid = 1'b0;
        check_val("bs_err", d_err, 1);
        check_val("bs_code", d_code, 3);
        check_val("bs_busy", d_busy, 0);
        check_val("bs_cnt", d_cnt, 1);

        // Zero data beats a coincident start; one count per edge
        start = 1'b1; len = 4'd2;
        tick();
        valid = 1'b1; data = 4'd0;
        tick();
        start = 1'b0; valid = 1'b0;
        check_val("pri_zd_code", d_code, 1);
        check_val("pri_zd_cnt", d_cnt, 2);

        // Gap timeout with MAX_GAP=0 beats a coincident start
        start = 1'b1; len = 4'd2;
        tick();
        valid = 1'b0;
        tick();
        start = 1'b0;
        check_val("pri_gap_err", d_err, 1);
        check_val("pri_gap_code", d_code, 2);
        check_val("pri_gap_cnt", d_cnt, 3);
        check_val("pri_gap_busy", d_busy, 0);

        // MAX_GAP=2: gap of 2 tolerated, third low sample times out
        do_reset();
        start = 1'b1; len = 4'd3;
        tick();
        start = 1'b0;
        beat(4'd1);
        valid = 1'b0;
        tick(); tick();
        check_val("mg_gap2_err", g_err, 0);
        check_val("mg_gap2_busy", g_busy, 1);
        beat(4'd2);
        check_val("mg_beat2", g_beat, 2);
        valid = 1'b0;
        tick(); tick();
        check_val("mg_gap3_pre", g_err, 0);
        tick();
        check_val("mg_to_err", g_err, 1);
        check_val("mg_to_code", g_code, 2);
        check_val("mg_to_busy", g_busy, 0);

        // CNT_W=2: five zero-length starts saturate err_cnt at 3
        do_reset();
        start = 1'b1; len = 4'd0;
        tick(); tick(); tick();
        check_val("sat_cnt3", c_cnt, 3);
        tick(); tick();
        start = 1'b0;
        check_val("sat_cnt5", c_cnt, 3);
        check_val("sat_code", c_code, 3);
        check_val("sat_busy", c_busy, 0);

        // Asynchronous reset mid-burst, then prompt restart
        do_reset();
        start = 1'b1; len = 4'd4;
        tick();
        start = 1'b0;
        beat(4'd1); beat(4'd2);
        check_val("mr_beat_pre", d_beat, 2);
        #2 rst = 1'b1;
        #1;
        check_val("mr_busy", d_busy, 0);
        check_val("mr_beat", d_beat, 0);
        check_val("mr_err", d_err, 0);
        check_val("mr_done", d_done, 0);
        tick();
        valid = 1'b0;
        rst = 1'b0;
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0;
        check_val("mr_no_err", d_err, 0);
        check_val("mr_restart_busy", d_busy, 1);
        beat(4'd9);
        check_val("mr_restart_done", d_done, 1);
        valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Whole-run watchdog so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
